// File: rtl/instr_encoder_if.sv
// Field-bundle request side and instruction-memory write side of the encoder.
// The encoder uses the slave modport; a producer/consumer uses master.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [3:0]  cond;
   logic [3:0]  cmd;
   logic        imm_sel;
   logic        s_l;
   logic [3:0]  rn;
   logic [3:0]  rd;
   logic [3:0]  rm;
   logic [23:0] imm;
   logic        flush;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic [6:0]  count;
   logic        full;
   logic        err;

   modport slave (
      input  in_valid, op, cond, cmd, imm_sel, s_l, rn, rd, rm, imm, flush,
      output in_ready, wr_en, wr_addr, wr_data, count, full, err
   );

   modport master (
      output in_valid, op, cond, cmd, imm_sel, s_l, rn, rd, rm, imm, flush,
      input  in_ready, wr_en, wr_addr, wr_data, count, full, err
   );
endinterface

// File: rtl/instr_encoder.sv
// Encodes DP / memory / branch field bundles into 32-bit instruction words
// and writes them sequentially into a 64-word program buffer.
module instr_encoder (
   input logic           clk,
   input logic           reset,
   instr_encoder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

   state_t      state;
   logic [5:0]  ptr;
   logic [6:0]  cnt;
   logic        wr_q;
   logic [5:0]  addr_q;
   logic [31:0] data_q;
   logic        full_q;
   logic        err_q;
   logic        accept;
   logic [11:0] src_dp;
   logic [11:0] src_mem;
   logic [31:0] enc;

   always_comb begin
      src_dp  = bus.imm_sel ? {4'b0000, bus.imm[7:0]} : {8'h00, bus.rm};
      src_mem = bus.imm_sel ? bus.imm[11:0]           : {8'h00, bus.rm};
      case (bus.op)
         2'b00:   enc = {bus.cond, 2'b00, bus.imm_sel, bus.cmd, bus.s_l,
                         bus.rn, bus.rd, src_dp};
         2'b01:   enc = {bus.cond, 2'b01, ~bus.imm_sel, 1'b1, 1'b1, 1'b0, 1'b0,
                         bus.s_l, bus.rn, bus.rd, src_mem};
         default: enc = {bus.cond, 2'b10, 2'b10, bus.imm};
      endcase
   end

   assign bus.in_ready = (state == IDLE) && reset;
   assign accept       = bus.in_valid && bus.in_ready;

   // The strobe is registered at accept, but a reset or flush arriving during
   // the WRITE cycle must still cancel it, hence the combinational gate.
   assign bus.wr_en   = wr_q && reset && !bus.flush;
   assign bus.wr_addr = addr_q;
   assign bus.wr_data = data_q;
   assign bus.count   = cnt;
   assign bus.full    = full_q;
   assign bus.err     = err_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         ptr    <= '0;
         cnt    <= '0;
         wr_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         full_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         wr_q  <= 1'b0;
         err_q <= 1'b0;
         if (bus.flush) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            full_q <= 1'b0;
         end else begin
            case (state)
               IDLE: if (accept) begin
                  if (bus.op == 2'b11) begin
                     err_q <= 1'b1;
                  end else begin
                     state  <= WRITE;
                     wr_q   <= 1'b1;
                     addr_q <= ptr;
                     data_q <= enc;
                  end
               end
               WRITE: begin
                  ptr <= ptr + 6'd1;
                  cnt <= cnt + 7'd1;
                  if (cnt == 7'd63) begin
                     state  <= FULL;
                     full_q <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
               FULL:    state <= FULL;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed vector table plus hand-written fill / flush / reset sequences.
module tb_instr_encoder;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   ptr_m  = 0;
   int   cnt_m  = 0;

   instr_encoder_if bus ();

   instr_encoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  cond;
      logic [3:0]  cmd;
      logic        imm_sel;
      logic        s_l;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [3:0]  rm;
      logic [23:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.op      = v.op;
      bus.cond    = v.cond;
      bus.cmd     = v.cmd;
      bus.imm_sel = v.imm_sel;
      bus.s_l     = v.s_l;
      bus.rn      = v.rn;
      bus.rd      = v.rd;
      bus.rm      = v.rm;
      bus.imm     = v.imm;
   endtask

   // One bundle through accept, write and the pointer/count update.
   task automatic apply(input vec_t v, input int idx);
      logic illegal;
      illegal = (v.op == 2'b11);
      @(negedge clk);
      drive(v);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d wr_en", idx), {31'b0, bus.wr_en}, {31'b0, !illegal});
      chk($sformatf("v%0d err", idx), {31'b0, bus.err}, {31'b0, illegal});
      if (!illegal) begin
         chk($sformatf("v%0d wr_addr", idx), {26'b0, bus.wr_addr}, ptr_m[31:0]);
         chk($sformatf("v%0d wr_data", idx), bus.wr_data, v.exp);
         chk($sformatf("v%0d in_ready busy", idx), {31'b0, bus.in_ready}, 32'd0);
         ptr_m = (ptr_m + 1) % 64;
         cnt_m = cnt_m + 1;
      end
      @(negedge clk);
      chk($sformatf("v%0d count", idx), {25'b0, bus.count}, cnt_m[31:0]);
      chk($sformatf("v%0d wr_en idle", idx), {31'b0, bus.wr_en}, 32'd0);
      chk($sformatf("v%0d err idle", idx), {31'b0, bus.err}, 32'd0);
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      ptr_m = 0;
      cnt_m = 0;
   endtask

   initial begin
      vecs[0] = '{2'b00, 4'hE, 4'h4, 1'b0, 1'b0, 4'd6,  4'd5,  4'd7,  24'h000000, 32'hE0865007};
      vecs[1] = '{2'b01, 4'hE, 4'h0, 1'b1, 1'b1, 4'd0,  4'd2,  4'd0,  24'h000004, 32'hE5902004};
      vecs[2] = '{2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0,  4'd0,  4'd0,  24'hFFFFFE, 32'hEAFFFFFE};
      vecs[3] = '{2'b11, 4'hE, 4'h4, 1'b0, 1'b0, 4'd1,  4'd2,  4'd3,  24'h000000, 32'h00000000};
      vecs[4] = '{2'b00, 4'h0, 4'h2, 1'b1, 1'b1, 4'd1,  4'd2,  4'd9,  24'h1234FF, 32'h025120FF};
      vecs[5] = '{2'b01, 4'hA, 4'h0, 1'b0, 1'b0, 4'd3,  4'd4,  4'd9,  24'hABCDEF, 32'hA7834009};
      vecs[6] = '{2'b00, 4'h1, 4'hC, 1'b0, 1'b1, 4'd15, 4'd14, 4'd13, 24'h000000, 32'h119FE00D};
      vecs[7] = '{2'b10, 4'h0, 4'hF, 1'b1, 1'b1, 4'd7,  4'd7,  4'd7,  24'h000010, 32'h0A000010};
      vecs[8] = '{2'b00, 4'hE, 4'h0, 1'b1, 1'b0, 4'd0,  4'd0,  4'd0,  24'h000080, 32'hE2000080};

      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      drive(vecs[0]);
      repeat (3) @(negedge clk);
      chk("rst in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("rst wr_en",    {31'b0, bus.wr_en},    32'd0);
      chk("rst wr_addr",  {26'b0, bus.wr_addr},  32'd0);
      chk("rst wr_data",  bus.wr_data,           32'd0);
      chk("rst count",    {25'b0, bus.count},    32'd0);
      chk("rst full",     {31'b0, bus.full},     32'd0);
      chk("rst err",      {31'b0, bus.err},      32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("post-rst in_ready", {31'b0, bus.in_ready}, 32'd1);

      for (int i = 0; i < 9; i++) apply(vecs[i], i);

      // Flush wins over a simultaneous valid bundle.
      @(negedge clk);
      drive(vecs[0]);
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      ptr_m = 0;
      cnt_m = 0;
      chk("flush prio wr_en", {31'b0, bus.wr_en}, 32'd0);
      chk("flush prio count", {25'b0, bus.count}, 32'd0);
      chk("flush prio in_ready", {31'b0, bus.in_ready}, 32'd1);

      // Fill all 64 words.
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         drive(vecs[i % 3]);
         bus.in_valid = 1'b1;
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk($sformatf("fill%0d wr_en", i), {31'b0, bus.wr_en}, 32'd1);
         chk($sformatf("fill%0d addr", i), {26'b0, bus.wr_addr}, i[31:0]);
         chk($sformatf("fill%0d data", i), bus.wr_data, vecs[i % 3].exp);
         @(negedge clk);
      end
      chk("full flag",     {31'b0, bus.full},     32'd1);
      chk("full count",    {25'b0, bus.count},    32'd64);
      chk("full in_ready", {31'b0, bus.in_ready}, 32'd0);

      // 65th bundle held valid must be ignored.
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("ovf%0d wr_en", i), {31'b0, bus.wr_en}, 32'd0);
      end
      bus.in_valid = 1'b0;
      chk("ovf count", {25'b0, bus.count}, 32'd64);
      chk("ovf full",  {31'b0, bus.full},  32'd1);

      pulse_flush();
      chk("flush count",    {25'b0, bus.count},    32'd0);
      chk("flush full",     {31'b0, bus.full},     32'd0);
      chk("flush in_ready", {31'b0, bus.in_ready}, 32'd1);
      apply(vecs[1], 100);

      // Flush during the WRITE cycle cancels the strobe and the count update.
      @(negedge clk);
      drive(vecs[2]);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b1;
      #1;
      chk("flush mid wr_en", {31'b0, bus.wr_en}, 32'd0);
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush mid count", {25'b0, bus.count}, 32'd0);
      chk("flush mid in_ready", {31'b0, bus.in_ready}, 32'd1);

      // Reset during WRITE suppresses the write and clears everything.
      @(negedge clk);
      drive(vecs[0]);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      reset        = 1'b0;
      #1;
      chk("rst mid wr_en",    {31'b0, bus.wr_en},    32'd0);
      chk("rst mid in_ready", {31'b0, bus.in_ready}, 32'd0);
      @(negedge clk);
      chk("rst mid wr_en2",  {31'b0, bus.wr_en},   32'd0);
      chk("rst mid wr_addr", {26'b0, bus.wr_addr}, 32'd0);
      chk("rst mid wr_data", bus.wr_data,          32'd0);
      chk("rst mid count",   {25'b0, bus.count},   32'd0);
      chk("rst mid full",    {31'b0, bus.full},    32'd0);
      chk("rst mid err",     {31'b0, bus.err},     32'd0);
      reset = 1'b1;
      ptr_m = 0;
      cnt_m = 0;
      apply(vecs[4], 200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
